combi_sweep_ctrl: RTL and testbench

- Sequencer that exhaustively exercises a 4-input/2-output combinational block (combi) in hardware.
- Drives a,b,c,d through all 16 input combinations in ascending order and samples x,y after a programmable settle time.
- Captures the two 16-entry truth tables and compares them against expected constants.
- Sits between combi and a start/status interface (board buttons/LEDs or a top-level test harness).

---
 rtl/combi_sweep_ctrl.sv | 145 ++++++++++++++
 tb/tb_combi_sweep_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/combi_sweep_ctrl.sv
// combi_sweep_ctrl: walks a 4-input combinational block through all 16
// input vectors, samples its two outputs after a settle time, captures the
// truth tables and compares them against expected constants.
module combi_sweep_ctrl #(
  parameter int unsigned HOLD  = 4,
  parameter logic [15:0] EXP_X = 16'h0000,
  parameter logic [15:0] EXP_Y = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        x_in,
  input  logic        y_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] x_table,
  output logic [15:0] y_table,
  output logic [4:0]  fail_cnt,
  output logic [3:0]  fail_idx
);

  // HOLD of zero behaves as a single settle cycle
  localparam int unsigned HOLD_EFF  = (HOLD < 1) ? 1 : HOLD;
  localparam int unsigned CW        = (HOLD_EFF > 1) ? $clog2(HOLD_EFF) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_EFF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [3:0]      vec;
  logic [CW-1:0]   hold_cnt;
  logic            mismatch;
  logic [4:0]      fail_cnt_nx;
  logic            drive_phase;

  // combi inputs follow the vector only while a sweep is active
  assign drive_phase  = (state == S_DRIVE) || (state == S_SAMPLE);
  assign {a, b, c, d} = drive_phase ? vec : 4'b0000;

  // compare the current sample against the expected tables
  always_comb begin
    mismatch    = (x_in != EXP_X[vec]) || (y_in != EXP_Y[vec]);
    fail_cnt_nx = fail_cnt + {4'b0000, mismatch};
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // next-state logic; abort outranks everything while a sweep runs
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_next = S_DRIVE;
      S_DRIVE: begin
        if (abort)                       state_next = S_IDLE;
        else if (hold_cnt == HOLD_LAST)  state_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (abort)             state_next = S_IDLE;
        else if (vec == 4'hF)  state_next = S_DONE;
        else                   state_next = S_DRIVE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // datapath: vector/settle counters, capture tables and result flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec      <= '0;
      hold_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      x_table  <= '0;
      y_table  <= '0;
      fail_cnt <= '0;
      fail_idx <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            vec      <= '0;
            hold_cnt <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            x_table  <= '0;
            y_table  <= '0;
            fail_cnt <= '0;
            fail_idx <= '0;
          end
        end
        S_DRIVE: begin
          if (abort) begin
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
          end else if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        S_SAMPLE: begin
          if (abort) begin
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
          end else begin
            x_table[vec] <= x_in;
            y_table[vec] <= y_in;
            fail_cnt     <= fail_cnt_nx;
            if (mismatch && (fail_cnt == 5'd0)) fail_idx <= vec;
            if (vec == 4'hF) begin
              busy <= 1'b0;
              done <= 1'b1;
              pass <= (fail_cnt_nx == 5'd0);
            end else begin
              vec      <= vec + 4'd1;
              hold_cnt <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_combi_sweep_ctrl.sv
// Bench for combi_sweep_ctrl: two instances (HOLD=4 and HOLD=0, the latter
// settling for one cycle) driven against a modelled combi x=a&b, y=c|d with
// randomly injected output faults.
module tb_combi_sweep_ctrl;

  localparam logic [15:0] EXPX = 16'hF000;
  localparam logic [15:0] EXPY = 16'hEEEE;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        start_s = '0;
  logic [1:0]        abort_s = '0;
  logic [1:0]        x_in_s;
  logic [1:0]        y_in_s;
  logic [1:0][3:0]   abcd_s;
  logic [1:0]        busy_s;
  logic [1:0]        done_s;
  logic [1:0]        pass_s;
  logic [1:0][15:0]  xtab_s;
  logic [1:0][15:0]  ytab_s;
  logic [1:0][4:0]   fcnt_s;
  logic [1:0][3:0]   fidx_s;

  // per-vector fault masks applied to the modelled combi outputs
  logic [15:0] xflip = '0;
  logic [15:0] yflip = '0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  assign x_in_s[0] = (abcd_s[0][3] & abcd_s[0][2]) ^ xflip[abcd_s[0]];
  assign y_in_s[0] = (abcd_s[0][1] | abcd_s[0][0]) ^ yflip[abcd_s[0]];
  assign x_in_s[1] = (abcd_s[1][3] & abcd_s[1][2]) ^ xflip[abcd_s[1]];
  assign y_in_s[1] = (abcd_s[1][1] | abcd_s[1][0]) ^ yflip[abcd_s[1]];

  combi_sweep_ctrl #(.HOLD(4), .EXP_X(EXPX), .EXP_Y(EXPY)) u_dut_h4 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
    .x_in(x_in_s[0]), .y_in(y_in_s[0]),
    .a(abcd_s[0][3]), .b(abcd_s[0][2]), .c(abcd_s[0][1]), .d(abcd_s[0][0]),
    .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
    .x_table(xtab_s[0]), .y_table(ytab_s[0]),
    .fail_cnt(fcnt_s[0]), .fail_idx(fidx_s[0])
  );

  combi_sweep_ctrl #(.HOLD(0), .EXP_X(EXPX), .EXP_Y(EXPY)) u_dut_h0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
    .x_in(x_in_s[1]), .y_in(y_in_s[1]),
    .a(abcd_s[1][3]), .b(abcd_s[1][2]), .c(abcd_s[1][1]), .d(abcd_s[1][0]),
    .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
    .x_table(xtab_s[1]), .y_table(ytab_s[1]),
    .fail_cnt(fcnt_s[1]), .fail_idx(fidx_s[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---- reference model -------------------------------------------------
  function automatic int unsigned cycles_per_vec(input int k);
    return (k == 0) ? 5 : 2;
  endfunction

  function automatic logic [15:0] good_x();
    logic [15:0] t = '0;
    for (int unsigned v = 0; v < 16; v++) t[v] = (v >= 12);
    return t;
  endfunction

  function automatic logic [15:0] good_y();
    logic [15:0] t = '0;
    for (int unsigned v = 0; v < 16; v++) t[v] = (v % 4) != 0;
    return t;
  endfunction

  function automatic logic [15:0] model_x();
    return good_x() ^ xflip;
  endfunction

  function automatic logic [15:0] model_y();
    return good_y() ^ yflip;
  endfunction

  function automatic logic [15:0] model_bad();
    return (model_x() ^ EXPX) | (model_y() ^ EXPY);
  endfunction

  function automatic logic [3:0] first_set(input logic [15:0] m);
    logic [3:0] r = '0;
    for (int i = 15; i >= 0; i--) if (m[i]) r = 4'(i);
    return r;
  endfunction

  // ---- helpers ----------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int k);
    start_s[k] = 1'b1;
    tick();
    start_s[k] = 1'b0;
  endtask

  task automatic check_tables(input int k, input logic [15:0] mask);
    logic [15:0] bad;
    bad = model_bad() & mask;
    check("x_table", xtab_s[k], model_x() & mask);
    check("y_table", ytab_s[k], model_y() & mask);
    check("fail_cnt", fcnt_s[k], $countones(bad));
    check("fail_idx", fidx_s[k], first_set(bad));
  endtask

  // runs a started sweep to completion; optionally pulses start at cycle start_at
  task automatic run_and_check(input int k, input int start_at);
    int unsigned h;
    int unsigned n;
    h = cycles_per_vec(k);
    n = 0;
    while (!done_s[k] && n < 40 * h) begin
      check("abcd_step", abcd_s[k], n / h);
      start_s[k] = (int'(n) == start_at);
      tick();
      n++;
    end
    start_s[k] = 1'b0;
    check("latency", n, 16 * h);
    check("done", done_s[k], 1);
    check("busy_end", busy_s[k], 0);
    check("abcd_done", abcd_s[k], 0);
    check("pass", pass_s[k], model_bad() == 16'h0000);
    check_tables(k, 16'hFFFF);
  endtask

  task automatic random_faults();
    if ($urandom_range(0, 3) == 0) begin
      xflip = '0;
      yflip = '0;
    end else begin
      xflip = 16'($urandom) & 16'($urandom);
      yflip = 16'($urandom) & 16'($urandom);
    end
  endtask

  task automatic check_reset_state(input int k);
    check("rst_busy", busy_s[k], 0);
    check("rst_done", done_s[k], 0);
    check("rst_pass", pass_s[k], 0);
    check("rst_abcd", abcd_s[k], 0);
    check("rst_xtab", xtab_s[k], 0);
    check("rst_ytab", ytab_s[k], 0);
    check("rst_fcnt", fcnt_s[k], 0);
    check("rst_fidx", fidx_s[k], 0);
  endtask

  initial begin
    int unsigned h;
    int unsigned n;
    int unsigned v;
    tick();
    tick();
    for (int k = 0; k < 2; k++) check_reset_state(k);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 2; k++) begin
      h = cycles_per_vec(k);

      // golden sweep
      xflip = '0;
      yflip = '0;
      do_start(k);
      check("busy_start", busy_s[k], 1);
      run_and_check(k, -1);

      // x stuck at 0: fails on 12..15
      xflip = good_x();
      do_start(k);
      run_and_check(k, -1);
      check("stuck_cnt", fcnt_s[k], 4);
      check("stuck_idx", fidx_s[k], 12);

      // abort in DONE has no effect
      abort_s[k] = 1'b1;
      tick();
      abort_s[k] = 1'b0;
      check("done_abort_done", done_s[k], 1);
      check("done_abort_xtab", xtab_s[k], 0);

      // start together with abort in DONE: start wins, results cleared
      xflip = '0;
      start_s[k] = 1'b1;
      abort_s[k] = 1'b1;
      tick();
      start_s[k] = 1'b0;
      abort_s[k] = 1'b0;
      check("restart_busy", busy_s[k], 1);
      check("restart_done", done_s[k], 0);
      check("restart_fcnt", fcnt_s[k], 0);
      check("restart_fidx", fidx_s[k], 0);
      check("restart_xtab", xtab_s[k], 0);
      run_and_check(k, -1);

      // random fault patterns, with a start pulse during some sweeps
      for (int it = 0; it < 6; it++) begin
        random_faults();
        do_start(k);
        run_and_check(k, ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 16 * h - 1)));
      end

      // random abort points, each followed by a clean sweep
      for (int it = 0; it < 4; it++) begin
        random_faults();
        do_start(k);
        n = $urandom_range(0, 16 * h - 1);
        for (int unsigned t = 0; t < n; t++) tick();
        v = n / h;
        abort_s[k] = 1'b1;
        tick();
        abort_s[k] = 1'b0;
        check("abort_busy", busy_s[k], 0);
        check("abort_done", done_s[k], 0);
        check("abort_pass", pass_s[k], 0);
        check("abort_abcd", abcd_s[k], 0);
        check_tables(k, 16'((32'd1 << v) - 1));
        tick();
        check("abort_idle_abcd", abcd_s[k], 0);
        xflip = '0;
        yflip = '0;
        do_start(k);
        run_and_check(k, -1);
      end
    end

    // asynchronous reset in the middle of vector 7
    xflip = '0;
    yflip = '0;
    do_start(0);
    n = 0;
    while (abcd_s[0] != 4'd7 && n < 200) begin
      tick();
      n++;
    end
    tick();
    check("pre_reset_busy", busy_s[0], 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state(0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_busy", busy_s[0], 0);
    check("post_reset_abcd", abcd_s[0], 0);
    do_start(0);
    run_and_check(0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
